// File: rtl/ped_signal_pkg.sv
// Shared types, default sizes and the vehicle-lamp legality check for the
// pedestrian signal controller.
package ped_signal_pkg;

   typedef enum logic [1:0] {
      DONT_WALK = 2'd0,
      WALK      = 2'd1,
      CLEARANCE = 2'd2
   } ped_state_e;

   localparam int PED_WALK_TICKS_DEF  = 4;
   localparam int PED_CLEAR_TICKS_DEF = 3;
   localparam int PED_CNT_W_DEF       = 8;

   // Exactly one vehicle lamp lit: odd parity, excluding all three lit.
   function automatic logic lamp_legal(input logic r, input logic y, input logic g);
      return (r ^ y ^ g) & ~(r & y & g);
   endfunction

endpackage

// File: rtl/ped_signal_ctrl_lamp_phase_decoder.sv
// Vehicle lamp decoder: red edge detect, combinational legality and the
// registered fault flag.
module lamp_phase_decoder
   import ped_signal_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic red,
   input  logic yellow,
   input  logic green,
   output logic red_rise,
   output logic legal,
   output logic fault
);

   logic red_q, red_d;
   logic fault_q, fault_d;

   always_comb begin
      legal    = lamp_legal(red, yellow, green);
      red_rise = red & ~red_q;
      red_d    = red;
      fault_d  = ~legal;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         red_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         red_q   <= red_d;
         fault_q <= fault_d;
      end
   end

   assign fault = fault_q;

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller downstream of the vehicle traffic light.
// Optional build macro PED_AUTO_RECALL_EN: every red phase raises a request.
module ped_signal_ctrl
   import ped_signal_pkg::*;
#(
   parameter int WALK_TICKS  = PED_WALK_TICKS_DEF,
   parameter int CLEAR_TICKS = PED_CLEAR_TICKS_DEF,
   parameter int CNT_W       = PED_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             red,
   input  logic             yellow,
   input  logic             green,
   input  logic             tick,
   input  logic             ped_button,
   output logic             walk,
   output logic             dont_walk,
   output logic [CNT_W-1:0] countdown,
   output logic             req_pending,
   output logic             fault
);

   localparam logic [CNT_W-1:0] WALK_INIT  = CNT_W'(WALK_TICKS);
   localparam logic [CNT_W-1:0] CLEAR_INIT = CNT_W'(CLEAR_TICKS);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   ped_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] countdown_q, countdown_d;
   logic             walk_q, walk_d;
   logic             dont_walk_q, dont_walk_d;
   logic             req_q, req_d;
   logic             served_q, served_d;

   logic red_rise, legal;
   logic recall, req_now, abort;

   lamp_phase_decoder u_decoder (
      .clk      (clk),
      .reset    (reset),
      .red      (red),
      .yellow   (yellow),
      .green    (green),
      .red_rise (red_rise),
      .legal    (legal),
      .fault    (fault)
   );

`ifdef PED_AUTO_RECALL_EN
   assign recall = red_rise;
`else
   assign recall = 1'b0;
`endif

   assign req_now = req_q | ped_button | recall;
   assign abort   = ~legal | ~red;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      countdown_d = countdown_q;
      walk_d      = walk_q;
      dont_walk_d = dont_walk_q;
      req_d       = req_q;
      served_d    = served_q;

      // A new red phase (or any non-red time) re-arms the one-WALK-per-red rule.
      if (red_rise || !red)
         served_d = 1'b0;
      if (state_q != WALK && (ped_button || recall))
         req_d = 1'b1;

      case (state_q)
         DONT_WALK: begin
            if (legal && red && !served_q && req_now) begin
               state_d     = WALK;
               walk_d      = 1'b1;
               dont_walk_d = 1'b0;
               cnt_d       = WALK_INIT;
               countdown_d = '0;
               req_d       = 1'b0;
            end
         end
         WALK: begin
            if (abort) begin
               state_d     = DONT_WALK;
               walk_d      = 1'b0;
               dont_walk_d = 1'b1;
               cnt_d       = '0;
               countdown_d = '0;
               served_d    = 1'b1;
            end else if (tick) begin
               if (cnt_q <= CNT_ONE) begin
                  state_d     = CLEARANCE;
                  walk_d      = 1'b0;
                  dont_walk_d = 1'b1;
                  cnt_d       = '0;
                  countdown_d = CLEAR_INIT;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         CLEARANCE: begin
            if (abort) begin
               state_d     = DONT_WALK;
               walk_d      = 1'b0;
               dont_walk_d = 1'b1;
               countdown_d = '0;
               served_d    = 1'b1;
            end else if (tick) begin
               if (countdown_q <= CNT_ONE) begin
                  state_d     = DONT_WALK;
                  dont_walk_d = 1'b1;
                  countdown_d = '0;
                  served_d    = 1'b1;
               end else begin
                  countdown_d = countdown_q - CNT_ONE;
                  dont_walk_d = ~dont_walk_q;
               end
            end
         end
         default: begin
            state_d     = DONT_WALK;
            walk_d      = 1'b0;
            dont_walk_d = 1'b1;
            cnt_d       = '0;
            countdown_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= DONT_WALK;
         cnt_q       <= '0;
         countdown_q <= '0;
         walk_q      <= 1'b0;
         dont_walk_q <= 1'b1;
         req_q       <= 1'b0;
         served_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         countdown_q <= countdown_d;
         walk_q      <= walk_d;
         dont_walk_q <= dont_walk_d;
         req_q       <= req_d;
         served_q    <= served_d;
      end
   end

   assign walk        = walk_q;
   assign dont_walk   = dont_walk_q;
   assign countdown   = countdown_q;
   assign req_pending = req_q;

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Directed, table-driven bench for ped_signal_ctrl (default build expectations,
// with the auto-recall difference handled in the final reset sequence).
module tb_ped_signal_ctrl;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             red, yellow, green, tick, ped_button;
   logic             walk, dont_walk, req_pending, fault;
   logic [CNT_W-1:0] countdown;

   int checks = 0;
   int passed = 0;

   typedef struct {
      logic [2:0]       lamp;   // {red, yellow, green}
      logic             tk;
      logic             btn;
      logic             e_walk;
      logic             e_dw;
      logic [CNT_W-1:0] e_cd;
      logic             e_req;
      logic             e_fault;
   } vec_t;

   vec_t vecs[$];

   localparam logic [2:0] L_R   = 3'b100;
   localparam logic [2:0] L_Y   = 3'b010;
   localparam logic [2:0] L_G   = 3'b001;
   localparam logic [2:0] L_RG  = 3'b101;
   localparam logic [2:0] L_OFF = 3'b000;

   ped_signal_ctrl #(.WALK_TICKS(4), .CLEAR_TICKS(3), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .red         (red),
      .yellow      (yellow),
      .green       (green),
      .tick        (tick),
      .ped_button  (ped_button),
      .walk        (walk),
      .dont_walk   (dont_walk),
      .countdown   (countdown),
      .req_pending (req_pending),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic drive(input logic [2:0] lamp, input logic tk, input logic btn);
      {red, yellow, green} = lamp;
      tick       = tk;
      ped_button = btn;
   endtask

   task automatic cycle_check(input string tag, input logic e_walk, input logic e_dw,
                              input logic [CNT_W-1:0] e_cd, input logic e_req, input logic e_fault);
      @(posedge clk);
      #1;
      check({tag, " walk"},        32'(walk),        32'(e_walk));
      check({tag, " dont_walk"},   32'(dont_walk),   32'(e_dw));
      check({tag, " countdown"},   32'(countdown),   32'(e_cd));
      check({tag, " req_pending"}, 32'(req_pending), 32'(e_req));
      check({tag, " fault"},       32'(fault),       32'(e_fault));
   endtask

   function automatic void add(input logic [2:0] lamp, input logic tk, input logic btn,
                               input logic w, input logic dw, input int cd,
                               input logic rq, input logic f);
      vec_t v;
      v.lamp = lamp; v.tk = tk; v.btn = btn;
      v.e_walk = w; v.e_dw = dw; v.e_cd = CNT_W'(cd); v.e_req = rq; v.e_fault = f;
      vecs.push_back(v);
   endfunction

   initial begin
      // Normal request / walk / clearance cycle.
      add(L_G, 0, 0,  0, 1, 0, 0, 0);
      add(L_G, 0, 1,  0, 1, 0, 1, 0);
      add(L_G, 0, 0,  0, 1, 0, 1, 0);
      add(L_Y, 0, 0,  0, 1, 0, 1, 0);
      add(L_R, 0, 0,  1, 0, 0, 0, 0);   // red rise grants WALK
      add(L_R, 1, 0,  1, 0, 0, 0, 0);
      add(L_R, 0, 0,  1, 0, 0, 0, 0);
      add(L_R, 0, 1,  1, 0, 0, 0, 0);   // press during WALK ignored
      add(L_R, 1, 0,  1, 0, 0, 0, 0);
      add(L_R, 1, 0,  1, 0, 0, 0, 0);
      add(L_R, 0, 0,  1, 0, 0, 0, 0);
      add(L_R, 1, 0,  0, 1, 3, 0, 0);   // fourth tick: clearance
      add(L_R, 0, 0,  0, 1, 3, 0, 0);
      add(L_R, 1, 0,  0, 0, 2, 0, 0);
      add(L_R, 1, 0,  0, 1, 1, 0, 0);
      add(L_R, 0, 0,  0, 1, 1, 0, 0);
      add(L_R, 1, 0,  0, 1, 0, 0, 0);   // clearance done, served
      add(L_R, 1, 0,  0, 1, 0, 0, 0);
      // Served within this red: request latches, no new WALK.
      add(L_R, 0, 1,  0, 1, 0, 1, 0);
      add(L_R, 0, 0,  0, 1, 0, 1, 0);
      add(L_Y, 0, 0,  0, 1, 0, 1, 0);
      add(L_G, 0, 0,  0, 1, 0, 1, 0);
      add(L_R, 0, 0,  1, 0, 0, 0, 0);
      // Abort: red drops mid-WALK.
      add(L_R, 1, 0,  1, 0, 0, 0, 0);
      add(L_R, 1, 0,  1, 0, 0, 0, 0);
      add(L_G, 0, 0,  0, 1, 0, 0, 0);
      add(L_G, 0, 1,  0, 1, 0, 1, 0);
      add(L_R, 0, 0,  1, 0, 0, 0, 0);
      // Fault during WALK, then legal yellow, then all-off with request kept.
      add(L_RG, 0, 0,  0, 1, 0, 0, 1);
      add(L_R,  0, 0,  0, 1, 0, 0, 0);
      add(L_Y,  0, 0,  0, 1, 0, 0, 0);
      add(L_Y,  0, 1,  0, 1, 0, 1, 0);
      add(L_OFF,0, 0,  0, 1, 0, 1, 1);
      add(L_R,  0, 0,  1, 0, 0, 0, 0);
      // Walk into clearance, stop with countdown=2 and a pending request.
      add(L_R, 1, 0,  1, 0, 0, 0, 0);
      add(L_R, 1, 0,  1, 0, 0, 0, 0);
      add(L_R, 1, 0,  1, 0, 0, 0, 0);
      add(L_R, 1, 0,  0, 1, 3, 0, 0);
      add(L_R, 1, 0,  0, 0, 2, 0, 0);
      add(L_R, 0, 1,  0, 0, 2, 1, 0);

      reset = 1'b1;
      drive(L_R, 0, 0);
      for (int i = 0; i < 3; i++) cycle_check($sformatf("reset%0d", i), 0, 1, 0, 0, 0);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].lamp, vecs[i].tk, vecs[i].btn);
         cycle_check($sformatf("v%0d", i), vecs[i].e_walk, vecs[i].e_dw,
                     vecs[i].e_cd, vecs[i].e_req, vecs[i].e_fault);
      end

      // Reset in CLEARANCE discards everything, including the pending request.
      reset = 1'b1;
      drive(L_R, 0, 0);
      cycle_check("mid_reset", 0, 1, 0, 0, 0);
      reset = 1'b0;
      drive(L_G, 0, 0);
      cycle_check("post_reset_green", 0, 1, 0, 0, 0);
      drive(L_R, 0, 0);
`ifdef PED_AUTO_RECALL_EN
      cycle_check("auto_recall_walk", 1, 0, 0, 0, 0);
`else
      cycle_check("no_request_no_walk", 0, 1, 0, 0, 0);
      // Button arriving on the grant cycle is absorbed into the WALK.
      drive(L_R, 0, 1);
      cycle_check("same_cycle_grant", 1, 0, 0, 0, 0);
      drive(L_R, 0, 0);
      cycle_check("walk_hold", 1, 0, 0, 0, 0);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/ped_signal_ctrl.md
Name: ped_signal_ctrl

Overview:
Pedestrian crossing controller sitting directly downstream of TrafficLightModule. It consumes the vehicle lamp outputs (red/yellow/green) plus a push-button and a slow timebase tick. It drives the pedestrian WALK / DONT_WALK lamps, the clearance flash, and a countdown display. A WALK interval is granted only while the vehicle light is steady red.

Parameters:
WALK_TICKS, 4, WALK duration in timebase ticks (1 .. 2**CNT_W-1)
CLEAR_TICKS, 3, flashing-clearance duration in ticks (1 .. 2**CNT_W-1)
CNT_W, 8, width of the internal tick counter and the countdown output

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
red  input  1  vehicle red lamp from TrafficLightModule
yellow  input  1  vehicle yellow lamp
green  input  1  vehicle green lamp
tick  input  1  one-clk timebase pulse, clk-synchronous
ped_button  input  1  pedestrian push-button, level, already debounced
walk  output  1  WALK lamp
dont_walk  output  1  DONT_WALK lamp (steady, or flashing during clearance)
countdown  output  CNT_W  seconds remaining in clearance, else 0
req_pending  output  1  latched pedestrian request
fault  output  1  illegal vehicle lamp combination seen

Behaviour:
- Interface: one clock, clk. Reset is reset, synchronous and active-high.
- Reset values: walk=0, dont_walk=1, countdown=0, req_pending=0, fault=0, state=DONT_WALK, served=0.
- Lamp decode: legal when exactly one of red/yellow/green is 1. Otherwise fault=1 for that cycle (registered, 1-clk latency). The FSM is forced to DONT_WALK and req_pending is kept.
- red_rise = red & ~red_q (registered previous red). served clears on red_rise or when red=0.
- Button: while state is not WALK, ped_button=1 sets req_pending on the next edge. Presses during WALK are ignored.
- FSM states: DONT_WALK, WALK, CLEARANCE.
- DONT_WALK -> WALK when the lamp is legal, red=1, served=0 and req_pending=1 (registered or arriving this cycle).
  - On entry: walk=1, dont_walk=0, counter=WALK_TICKS, req_pending cleared.
  - A button press on the entry cycle is absorbed.
- WALK: counter decrements on each tick. On a tick with counter==1 -> CLEARANCE.
  - On CLEARANCE entry: walk=0, dont_walk=1, countdown=CLEAR_TICKS.
- CLEARANCE: on each tick, dont_walk toggles and countdown decrements.
  - On a tick with countdown==1 -> DONT_WALK: countdown=0, dont_walk=1 steady, served=1.
- Abort: red=0 or fault while in WALK or CLEARANCE -> DONT_WALK next edge. Outputs go to reset values except req_pending. served=1.
- All outputs are registered; output latency is 1 clk after the causing input edge.
- tick with no state change has no effect. Counters never wrap; decrement is gated at 1.
- Reset mid-operation: the next edge returns all state to reset values and discards any pending request.

Optional Feature:
PED_AUTO_RECALL_EN
- Defined: every red_rise sets req_pending internally, so WALK is granted on every red phase; ped_button still works.
- Undefined: WALK is granted only after a ped_button request.

Decomposition:
- Package ped_signal_pkg holds:
  - state enum {DONT_WALK, WALK, CLEARANCE}
  - default constants PED_WALK_TICKS_DEF=4, PED_CLEAR_TICKS_DEF=3, PED_CNT_W_DEF=8
  - lamp-legal check function
- Sub-module lamp_phase_decoder: registers red, produces red_rise and the registered fault/legal flags.
- FSM and counters stay in ped_signal_ctrl.

Test Plan:
- Reset held 3 clk with red=1, ped_button=0 -> walk=0, dont_walk=1, countdown=0, req_pending=0, fault=0.
- Green, press ped_button 1 clk, then red rises; tick every 4 clk -> req_pending=1 until red. walk=1 on the next edge for 4 ticks. Then countdown 3,2,1 with dont_walk toggling each tick. Then countdown=0, dont_walk steady 1.
- Served within red phase: a second press during the same red after clearance -> req_pending=1, no new WALK until green then red again.
- Abort: red drops to 0 (green=1) during WALK at countdown tick 2 -> next edge walk=0, dont_walk=1, countdown=0.
- Fault: red=1 and green=1 for 1 clk during WALK -> fault=1 one clk later, state DONT_WALK; yellow alone -> fault=0.
- Reset asserted in CLEARANCE with countdown=2 -> next edge all outputs at reset values; with PED_AUTO_RECALL_EN defined, the next red_rise grants WALK without a button press.
